// File: rtl/wave_frame_reader.sv
// wave_frame_reader
// Reads one frame of N = 2^(bw_dpram-1) samples from one half of a dual-port
// wave cache, starting at the oldest sample and wrapping within the half.
// Each sample is multiplied by a window coefficient and passed to the FFT stage
// through a 4-entry output FIFO with valid/ready handshaking.
//
// Ports
//   Clock     : single clock, all state on the rising edge
//   Reset     : asynchronous, active-low reset
//   Start     : one-cycle frame request (accepted when idle, or on the final
//               transfer of the current frame)
//   Channel   : cache half to read, latched on accepted Start
//   BaseAddr  : offset of the oldest sample in the half, latched on accepted Start
//   RamAddr   : cache read address {channel, offset}
//   RamData   : cache read data, valid one cycle after RamAddr
//   CoefAddr  : window ROM address (sample index)
//   CoefData  : window coefficient (unsigned Q0.bw_coef), valid one cycle after CoefAddr
//   OutData   : windowed sample (FIFO head)
//   OutValid  : OutData/OutLast valid
//   OutReady  : downstream accept
//   OutLast   : marks the last sample (index N-1) of the frame
//   Busy      : frame in progress
module wave_frame_reader #(
    parameter int bw_dpram = 12,
    parameter int bw_data  = 16,
    parameter int bw_coef  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Channel,
    input  logic [bw_dpram-2:0]   BaseAddr,
    output logic [bw_dpram-1:0]   RamAddr,
    input  logic [bw_data-1:0]    RamData,
    output logic [bw_dpram-2:0]   CoefAddr,
    input  logic [bw_coef-1:0]    CoefData,
    output logic [bw_data-1:0]    OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutLast,
    output logic                  Busy
);

    localparam int aw = bw_dpram - 1;
    localparam int pw = bw_data + bw_coef + 1;
    localparam logic [aw-1:0] last_idx = {aw{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    logic                ch_r;
    logic [aw-1:0]       base_r;
    logic [aw-1:0]       idx_r;          // next sample index to issue
    logic [bw_dpram-1:0] ram_addr_r;
    logic [aw-1:0]       coef_addr_r;
    logic                issue_r;        // RamAddr/CoefAddr carry a live read this cycle
    logic                issue_last_r;
    logic                rd_valid_r;     // RamData/CoefData carry a live read this cycle
    logic                rd_last_r;
    logic [2:0]          credit_r;       // reads in flight plus FIFO occupancy

    logic [bw_data-1:0]  fifo_data_r [0:3];
    logic [3:0]          fifo_last_r;
    logic [1:0]          wr_ptr_r;
    logic [1:0]          rd_ptr_r;
    logic [2:0]          count_r;

    logic                out_valid_s;
    logic                head_last_s;
    logic                pop_s;
    logic                start_acc_s;
    logic                load_s;
    logic [2:0]          credit_nxt_s;
    logic signed [pw-1:0] data_ext_s;
    logic signed [pw-1:0] coef_ext_s;
    logic signed [pw-1:0] prod_s;
    logic [bw_data-1:0]  wr_data_s;

    // Handshake, issue decision, credit update and window multiply
    always_comb begin
        out_valid_s  = 1'b0;
        head_last_s  = 1'b0;
        pop_s        = 1'b0;
        start_acc_s  = 1'b0;
        load_s       = 1'b0;
        credit_nxt_s = credit_r;
        data_ext_s   = '0;
        coef_ext_s   = '0;
        prod_s       = '0;
        wr_data_s    = '0;

        out_valid_s = (count_r != 3'd0);
        head_last_s = fifo_last_r[rd_ptr_r];
        pop_s       = out_valid_s && OutReady;

        // A Start coinciding with the final transfer is taken as the next frame.
        if (state_r == ST_IDLE) begin
            start_acc_s = Start;
        end else if (state_r == ST_DRAIN) begin
            start_acc_s = Start && pop_s && head_last_s;
        end else begin
            start_acc_s = 1'b0;
        end

        // With 4 credits out, a transfer this cycle frees the slot for a new read.
        if (state_r == ST_RUN) begin
            load_s = (credit_r < 3'd4) || pop_s;
        end else begin
            load_s = 1'b0;
        end

        credit_nxt_s = credit_r + {2'b00, (start_acc_s | load_s)} - {2'b00, pop_s};

        // Signed sample times zero-extended coefficient; the arithmetic shift
        // floors toward -inf and the cast keeps the low bw_data bits.
        data_ext_s = {{(bw_coef + 1){RamData[bw_data-1]}}, RamData};
        coef_ext_s = {{(bw_data + 1){1'b0}}, CoefData};
        prod_s     = data_ext_s * coef_ext_s;
        wr_data_s  = bw_data'(prod_s >>> bw_coef);
    end

    // Frame sequencer: state, latched request and registered read addresses
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            ch_r         <= 1'b0;
            base_r       <= '0;
            idx_r        <= '0;
            ram_addr_r   <= '0;
            coef_addr_r  <= '0;
            issue_r      <= 1'b0;
            issue_last_r <= 1'b0;
            credit_r     <= 3'd0;
        end else begin
            credit_r <= credit_nxt_s;
            if (start_acc_s) begin
                // Index 0 is issued directly from the request inputs.
                ch_r         <= Channel;
                base_r       <= BaseAddr;
                ram_addr_r   <= {Channel, BaseAddr};
                coef_addr_r  <= '0;
                idx_r        <= aw'(1'b1);
                issue_r      <= 1'b1;
                issue_last_r <= 1'b0;
                state_r      <= ST_RUN;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        issue_r      <= 1'b0;
                        issue_last_r <= 1'b0;
                    end
                    ST_RUN: begin
                        if (load_s) begin
                            // Offset wraps inside the half; channel bit is untouched.
                            ram_addr_r   <= {ch_r, base_r + idx_r};
                            coef_addr_r  <= idx_r;
                            idx_r        <= idx_r + aw'(1'b1);
                            issue_r      <= 1'b1;
                            issue_last_r <= (idx_r == last_idx);
                            if (idx_r == last_idx) begin
                                state_r <= ST_DRAIN;
                            end
                        end else begin
                            issue_r      <= 1'b0;
                            issue_last_r <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        issue_r      <= 1'b0;
                        issue_last_r <= 1'b0;
                        if (pop_s && head_last_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        issue_r      <= 1'b0;
                        issue_last_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read-data pipeline and 4-entry output FIFO
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            fifo_last_r <= 4'd0;
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i] <= '0;
            end
        end else begin
            rd_valid_r <= issue_r;
            rd_last_r  <= issue_last_r;
            // Credits guarantee a free slot whenever read data arrives.
            if (rd_valid_r) begin
                fifo_data_r[wr_ptr_r] <= wr_data_s;
                fifo_last_r[wr_ptr_r] <= rd_last_r;
                wr_ptr_r              <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r <= count_r + {2'b00, rd_valid_r} - {2'b00, pop_s};
        end
    end

    assign RamAddr  = ram_addr_r;
    assign CoefAddr = coef_addr_r;
    assign OutData  = fifo_data_r[rd_ptr_r];
    assign OutValid = out_valid_s;
    assign OutLast  = out_valid_s && head_last_s;
    assign Busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_wave_frame_reader.sv
// Directed testbench for wave_frame_reader with bw_dpram=4 (N=8), 16-bit
// samples and coefficients. Cache and window ROM are small arrays read with
// one cycle of latency; expected values are written out by hand.
module tb_wave_frame_reader;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Channel;
    logic [2:0]  BaseAddr;
    logic [3:0]  RamAddr;
    logic [15:0] RamData;
    logic [2:0]  CoefAddr;
    logic [15:0] CoefData;
    logic [15:0] OutData;
    logic        OutValid;
    logic        OutReady;
    logic        OutLast;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] ram  [0:15];
    logic [15:0] coef [0:7];
    logic [15:0] q_data [$];
    logic        q_last [$];

    logic [3:0]  exp_addr2 [0:7] = '{4'd14, 4'd15, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    logic [15:0] exp_dat2  [0:7] = '{16'h0380, 16'h0400, 16'h0080, 16'h0100,
                                     16'h0180, 16'h0200, 16'h0280, 16'h0300};
    // 0x8000*0xFFFF: -32768*65535/65536 = -32767.5 -> floor -32768 = 0x8000
    // 0xFFFF*0x0001: -1/65536 -> floor -1 = 0xFFFF
    // 0x7FFF*0xFFFF: 32766.5 -> 0x7FFE ; 3*0.5 -> 1 ; -3*0.5 -> -2 = 0xFFFE
    logic [15:0] exp_dat3  [0:7] = '{16'h8000, 16'hFFFF, 16'h7FFE, 16'h0001,
                                     16'hFFFE, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] exp_dat5  [0:7] = '{16'h0018, 16'h0020, 16'h0028, 16'h0030,
                                     16'h0038, 16'h0040, 16'h0008, 16'h0010};

    wave_frame_reader #(
        .bw_dpram(4),
        .bw_data (16),
        .bw_coef (16)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Channel (Channel),
        .BaseAddr(BaseAddr),
        .RamAddr (RamAddr),
        .RamData (RamData),
        .CoefAddr(CoefAddr),
        .CoefData(CoefData),
        .OutData (OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .OutLast (OutLast),
        .Busy    (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Cache and window ROM with one-cycle read latency
    always @(posedge Clock) begin
        RamData  <= ram[RamAddr];
        CoefData <= coef[CoefAddr];
    end

    // Record every transfer between edges
    always @(negedge Clock) begin
        if (Reset && OutValid && OutReady) begin
            q_data.push_back(OutData);
            q_last.push_back(OutLast);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle Start; returns in the first cycle after acceptance (t+1)
    task automatic start_frame(input logic ch, input logic [2:0] base);
        Start    = 1'b1;
        Channel  = ch;
        BaseAddr = base;
        tick();
        Start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && Busy; i++) begin
            tick();
        end
        chk(tag, {15'd0, Busy}, 16'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Channel  = 1'b0;
        BaseAddr = 3'd0;
        OutReady = 1'b1;
        for (int j = 0; j < 16; j++) ram[j] = 16'h0000;
        for (int j = 0; j < 8; j++) coef[j] = 16'h8000;

        // Reset state
        #2 Reset = 1'b0;
        #1;
        chk("rst_valid", {15'd0, OutValid}, 16'd0);
        chk("rst_busy",  {15'd0, Busy}, 16'd0);
        chk("rst_data",  OutData, 16'd0);
        chk("rst_addr",  {12'd0, RamAddr}, 16'd0);
        @(negedge Clock);
        Reset = 1'b1;
        tick();

        // Constant data: 0x4000 * 0.5 = 0x2000, 3-cycle latency, 8 samples
        for (int j = 8; j < 16; j++) ram[j] = 16'h4000;
        start_frame(1'b1, 3'd0);
        chk("t1_busy", {15'd0, Busy}, 16'd1);
        chk("t1_nv1", {15'd0, OutValid}, 16'd0);
        tick();
        chk("t1_nv2", {15'd0, OutValid}, 16'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_valid%0d", k), {15'd0, OutValid}, 16'd1);
            chk($sformatf("t1_data%0d", k), OutData, 16'h2000);
            chk($sformatf("t1_last%0d", k), {15'd0, OutLast}, (k == 7) ? 16'd1 : 16'd0);
            tick();
        end
        chk("t1_idle", {15'd0, Busy}, 16'd0);
        chk("t1_nvend", {15'd0, OutValid}, 16'd0);

        // Wrapping base offset within channel 1
        for (int j = 0; j < 8; j++) ram[8 + j] = 16'h0100 * 16'(j + 1);
        start_frame(1'b1, 3'd6);
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8) begin
                chk($sformatf("t2_ramaddr%0d", c - 1), {12'd0, RamAddr}, {12'd0, exp_addr2[c - 1]});
                chk($sformatf("t2_coefaddr%0d", c - 1), {13'd0, CoefAddr}, 16'(c - 1));
            end
            if (c >= 3) begin
                chk($sformatf("t2_data%0d", c - 3), OutData, exp_dat2[c - 3]);
            end
            tick();
        end
        chk("t2_idle", {15'd0, Busy}, 16'd0);

        // Arithmetic corner cases on channel 0
        ram[0] = 16'h8000; coef[0] = 16'hFFFF;
        ram[1] = 16'hFFFF; coef[1] = 16'h0001;
        ram[2] = 16'h7FFF; coef[2] = 16'hFFFF;
        ram[3] = 16'h0003; coef[3] = 16'h8000;
        ram[4] = 16'hFFFD; coef[4] = 16'h8000;
        start_frame(1'b0, 3'd0);
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_data%0d", k), OutData, exp_dat3[k]);
            tick();
        end
        for (int j = 0; j < 8; j++) coef[j] = 16'h8000;

        // Back-pressure: 10 stalled cycles after two transfers
        q_data.delete();
        q_last.delete();
        start_frame(1'b1, 3'd0);
        tick();
        tick();
        tick();
        tick();
        OutReady = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t4_stall_valid%0d", c), {15'd0, OutValid}, 16'd1);
            chk($sformatf("t4_stall_data%0d", c), OutData, 16'h0180);
            tick();
        end
        // Six reads issued, two transferred: four credits, issue frozen at index 5
        chk("t4_frozen_addr", {12'd0, RamAddr}, 16'd13);
        OutReady = 1'b1;
        wait_idle("t4_timeout");
        chk("t4_count", 16'(q_data.size()), 16'd8);
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            chk($sformatf("t4_data%0d", k), q_data[k], 16'h0080 * 16'(k + 1));
            chk($sformatf("t4_last%0d", k), {15'd0, q_last[k]}, (k == 7) ? 16'd1 : 16'd0);
        end

        // Start during RUN ignored; Start on final transfer opens next frame
        for (int j = 0; j < 8; j++) ram[j] = 16'h0010 * 16'(j + 1);
        q_data.delete();
        q_last.delete();
        start_frame(1'b1, 3'd0);
        tick();
        tick();
        Start    = 1'b1;
        Channel  = 1'b0;
        BaseAddr = 3'd5;
        tick();
        Start = 1'b0;
        chk("t5_ign_addr3", {12'd0, RamAddr}, 16'd11);
        tick();
        chk("t5_ign_addr4", {12'd0, RamAddr}, 16'd12);
        for (int i = 0; i < 20 && !(OutValid && OutLast); i++) begin
            tick();
        end
        chk("t5_last_seen", {15'd0, OutLast}, 16'd1);
        Start    = 1'b1;
        Channel  = 1'b0;
        BaseAddr = 3'd2;
        tick();
        Start = 1'b0;
        chk("t5_busy_next", {15'd0, Busy}, 16'd1);
        chk("t5_addr_next", {12'd0, RamAddr}, 16'd2);
        chk("t5_count1", 16'(q_data.size()), 16'd8);
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            chk($sformatf("t5_f1_data%0d", k), q_data[k], 16'h0080 * 16'(k + 1));
            chk($sformatf("t5_f1_last%0d", k), {15'd0, q_last[k]}, (k == 7) ? 16'd1 : 16'd0);
        end
        q_data.delete();
        q_last.delete();
        wait_idle("t5_timeout");
        chk("t5_count2", 16'(q_data.size()), 16'd8);
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            chk($sformatf("t5_f2_data%0d", k), q_data[k], exp_dat5[k]);
        end

        // Reset while sample 4 is at the head
        start_frame(1'b1, 3'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_pre_data", OutData, 16'h0280);
        Reset = 1'b0;
        #1;
        chk("t6_rst_valid", {15'd0, OutValid}, 16'd0);
        chk("t6_rst_last",  {15'd0, OutLast}, 16'd0);
        chk("t6_rst_busy",  {15'd0, Busy}, 16'd0);
        chk("t6_rst_data",  OutData, 16'd0);
        chk("t6_rst_ram",   {12'd0, RamAddr}, 16'd0);
        chk("t6_rst_coef",  {13'd0, CoefAddr}, 16'd0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t6_quiet%0d", i), {14'd0, Busy, OutValid}, 16'd0);
        end
        start_frame(1'b1, 3'd0);
        tick();
        tick();
        chk("t6_restart_valid", {15'd0, OutValid}, 16'd1);
        chk("t6_restart_data", OutData, 16'h0080);
        wait_idle("t6_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
